uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter OVS, default 16, oversampling ticks per bit.
REQ-004 sysclk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 UART_RX  input  1  asynchronous serial line; idle high.
REQ-007 rx_ack  input  1  one-cycle pulse from the CPU peripheral bus when it reads the data register.
REQ-008 rx_data  output  8  last received byte.
REQ-009 rx_valid  output  1  byte available; level, held until acknowledged.
REQ-010 frame_err  output  1  sticky flag: stop bit sampled low.
REQ-011 overrun  output  1  sticky flag: byte lost because rx_valid was still set.
REQ-012 rx_irq  output  1  equals rx_valid OR frame_err OR overrun; feeds the CPU interrupt input.

Function
REQ-013 UART_RX SHALL pass through a 2-flop synchronizer before any use; it adds 2 cycles of latency.
REQ-014 A tick SHALL pulse every DIV = round(CLK_HZ/(BAUD*OVS)) cycles, which is 651 at the defaults; the tick counter resets to 0 on every entry to START.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY when enabled).
REQ-016 IDLE->START SHALL occur on a synchronized high-to-low transition only; a line held low never re-triggers.
REQ-017 In START, the line SHALL be sampled at tick OVS/2; if high, the FSM returns to IDLE (false start, no flags); if low, it enters DATA.
REQ-018 In DATA, 8 bits SHALL be sampled LSB first, each OVS ticks after the previous sample, into a shift register.
REQ-019 In STOP, the line SHALL be sampled OVS ticks after the last data or parity sample, and the FSM returns to IDLE the cycle after that sample.
REQ-020 Stop sample high: rx_data loads and rx_valid sets on the cycle after the sample.
REQ-021 Stop sample low: frame_err sets, the byte is discarded, and rx_data/rx_valid are unchanged.
REQ-022 rx_ack SHALL clear rx_valid, frame_err and overrun on the next edge.
REQ-023 Byte completes while rx_valid=1 and rx_ack=0: overrun sets and the old rx_data is kept.
REQ-024 Byte completes in the same cycle as rx_ack: the new byte loads, rx_valid stays 1, and overrun does not set.
REQ-025 rx_ack while rx_valid=0 SHALL have no effect other than clearing the flags.

Reset
REQ-026 reset low SHALL immediately force IDLE, the tick counter, bit counter and shift register to 0, rx_data=0x00, and rx_valid, frame_err, overrun, rx_irq to 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, the next falling edge starts a fresh frame.
REQ-028 The synchronizer flops SHALL reset to 1 (idle line).

Configuration
REQ-029 With UART_RX_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP and sample one even-parity bit; on mismatch, output parity_err (1 bit, sticky, cleared by rx_ack, ORed into rx_irq) sets and the byte is discarded.
REQ-030 Without UART_RX_PARITY_EN, the frame is 8N1, the PARITY state and the parity_err port do not exist, and the timing of REQ-019 applies directly after bit 7.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the OVS constant and a function computing DIV from CLK_HZ and BAUD.
REQ-032 Sub-module uart_baud_tick SHALL contain the divider and tick generator, with a restart input.

Verification
REQ-033 Defaults, send 0xA5 8N1 at 9600 baud -> rx_valid rises within 1 cycle after the mid-stop sample, rx_data=0xA5, no flags.
REQ-034 Low glitch of 3000 cycles on the idle line -> no rx_valid, no flags, FSM back in IDLE.
REQ-035 Send 0x3C with stop bit low -> frame_err=1, rx_valid=0, rx_irq=1; rx_ack pulse -> frame_err=0.
REQ-036 Send 0x11 then 0x22 without acknowledging -> rx_data=0x11, overrun=1; repeat with rx_ack in the completion cycle of 0x22 -> rx_data=0x22, rx_valid=1, overrun=0.
REQ-037 Assert reset during data bit 4 of 0xFF, release, then send 0x5A -> all outputs 0 during reset, then rx_data=0x5A.
REQ-038 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1, rx_valid=0; send 0x07 with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit and the PARITY state).
package uart_pkg;

   // Default number of baud ticks per serial bit
   localparam int unsigned OVS_DEFAULT = 16;

   // Payload width of one serial frame
   localparam int unsigned DATA_BITS = 8;

   // Receiver FSM states; PARITY only exists when parity checking is built in
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } rx_state_e;

   // Clock cycles per baud tick: round(clk_hz / (baud * ovs)), never below 1
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned ovs);
      int unsigned den;
      int unsigned div;
      den = baud * ovs;
      div = (den == 0) ? 1 : (clk_hz + den / 2) / den;
      return (div == 0) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-cycle tick every DIV clocks, phase restartable.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned OVS    = OVS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned DIV     = calc_div(CLK_HZ, BAUD, OVS);
   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Divider count and tick decode; restart realigns the phase to zero
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q == DIV_MAX) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Divider state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver front end: synchronizer, oversampled 8N1 deframer and CPU-facing
// data/status registers with interrupt. Optional macro UART_RX_PARITY_EN adds an
// even-parity bit between data and stop plus a sticky parity_err output.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned OVS    = OVS_DEFAULT
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 UART_RX,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 rx_irq
);

   localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
   localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

   logic sync1_q, sync2_q, prev_q;
   logic fall_c;
   logic restart_c;
   logic tick;
   logic keep_c;

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 rx_irq_q, rx_irq_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   // Two-flop synchronizer for the async line plus one history flop for edge detect
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= UART_RX;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // High-to-low transition of the synchronized line
   assign fall_c = prev_q & ~sync2_q;

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD),
      .OVS    (OVS)
   ) u_tick (
      .clk     (sysclk),
      .rst_n   (reset),
      .restart (restart_c),
      .tick    (tick)
   );

   // Deframer FSM, shift register and CPU-visible register updates
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      restart_c   = 1'b0;
      keep_c      = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = parity_err_q;
      keep_c       = ~par_bad_q;
`endif

      // A CPU read clears the level and the sticky flags; events below override
      if (rx_ack) begin
         rx_valid_d  = 1'b0;
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (fall_c) begin
               state_d   = ST_START;
               tcnt_d    = '0;
               bcnt_d    = '0;
               restart_c = 1'b1;
`ifdef UART_RX_PARITY_EN
               par_bad_d = 1'b0;
`endif
            end
         end

         ST_START: begin
            if (tick) begin
               if (tcnt_q == HALF_LAST) begin
                  tcnt_d  = '0;
                  state_d = sync2_q ? ST_IDLE : ST_DATA;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (tcnt_q == BIT_LAST) begin
                  tcnt_d  = '0;
                  shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                  bcnt_d  = bcnt_q + BW'(1);
                  if (bcnt_q == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (tcnt_q == BIT_LAST) begin
                  tcnt_d    = '0;
                  state_d   = ST_STOP;
                  par_bad_d = (^shift_q) ^ sync2_q;
                  if ((^shift_q) ^ sync2_q) begin
                     parity_err_d = 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               if (tcnt_q == BIT_LAST) begin
                  tcnt_d  = '0;
                  state_d = ST_IDLE;
                  if (!sync2_q) begin
                     frame_err_d = 1'b1;
                  end else if (keep_c) begin
                     // Unread byte still pending: keep it and flag the loss
                     if (rx_valid_q && !rx_ack) begin
                        overrun_d = 1'b1;
                     end else begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                     end
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rx_irq_d = rx_valid_d | frame_err_d | overrun_d;
`ifdef UART_RX_PARITY_EN
      rx_irq_d = rx_irq_d | parity_err_d;
`endif
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         rx_irq_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         rx_irq_q    <= rx_irq_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_irq    = rx_irq_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend, run at a fast baud so frames stay short.
module tb_uart_rx_frontend;

   localparam int unsigned CLK_HZ  = 3_200_000;
   localparam int unsigned BAUD    = 100_000;
   localparam int unsigned OVS     = 16;
   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;   // 32 clocks per serial bit
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif
   // Middle of the stop bit plus synchronizer latency, measured from the start edge
   localparam int unsigned EXP_LAT = (FRAME_BITS - 1) * BIT_CYC + BIT_CYC / 2 + 2;
   localparam int unsigned LAT_TOL = 4;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       ferr;
      logic       ovr;
      logic       perr;
   } exp_t;

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      logic       ack_first;
      exp_t       exp;
   } vec_t;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       uart_rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       rx_irq;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned lat;
   exp_t        sb_q[$];
   vec_t        vecs[8];

   uart_rx_frontend #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD),
      .OVS    (OVS)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .UART_RX   (uart_rx),
      .rx_ack    (rx_ack),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .rx_irq    (rx_irq)
   );

   always #5 sysclk = ~sysclk;

   function automatic exp_t mk_exp(input logic [7:0] d, input logic v, input logic f,
                                   input logic o, input logic p);
      exp_t e;
      e.data = d; e.valid = v; e.ferr = f; e.ovr = o; e.perr = p;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic [7:0] tx, input logic stop, input logic ack,
                                   input logic [7:0] d, input logic v, input logic f,
                                   input logic o);
      vec_t r;
      r.tx = tx; r.stop = stop; r.ack_first = ack;
      r.exp = mk_exp(d, v, f, o, 1'b0);
      return r;
   endfunction

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input exp_t e);
      logic irq;
      irq = e.valid | e.ferr | e.ovr | e.perr;
      chk({name, ".rx_data"},   rx_data,            e.data);
      chk({name, ".rx_valid"},  {7'd0, rx_valid},   {7'd0, e.valid});
      chk({name, ".frame_err"}, {7'd0, frame_err},  {7'd0, e.ferr});
      chk({name, ".overrun"},   {7'd0, overrun},    {7'd0, e.ovr});
      chk({name, ".rx_irq"},    {7'd0, rx_irq},     {7'd0, irq});
`ifdef UART_RX_PARITY_EN
      chk({name, ".parity_err"}, {7'd0, parity_err}, {7'd0, e.perr});
`endif
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      cyc(1);
      rx_ack = 1'b0;
   endtask

   // One frame: start, 8 data LSB first, optional parity, stop, one idle bit
   task automatic send_frame(input logic [7:0] tx, input logic stop);
      uart_rx = 1'b0;
      cyc(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         uart_rx = tx[i];
         cyc(BIT_CYC);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx = (^tx) ^ par_flip;
      cyc(BIT_CYC);
`endif
      uart_rx = stop;
      cyc(BIT_CYC);
      uart_rx = 1'b1;
      cyc(BIT_CYC);
   endtask

   task automatic sb_check(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
      end else begin
         e = sb_q.pop_front();
         chk_all(name, e);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no end of test, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      vecs[0] = mk_vec(8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
      vecs[1] = mk_vec(8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      vecs[2] = mk_vec(8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
      vecs[3] = mk_vec(8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      vecs[4] = mk_vec(8'hC3, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
      vecs[5] = mk_vec(8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      vecs[6] = mk_vec(8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      vecs[7] = mk_vec(8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0);

      reset   = 1'b0;
      uart_rx = 1'b1;
      rx_ack  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      cyc(3);
      chk_all("reset", mk_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      reset = 1'b1;
      cyc(5);

      // First byte with rx_valid rise time measured from the start edge
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int i = 1; i <= 600; i++) begin
               cyc(1);
               if (rx_valid === 1'b1) begin
                  lat = i;
                  break;
               end
            end
         end
      join
      n_cmp++;
      if (lat + LAT_TOL < EXP_LAT || lat > EXP_LAT + LAT_TOL) begin
         n_bad++;
         $display("FAIL a5_latency: got %0d cycles, expected %0d +/- %0d", lat, EXP_LAT, LAT_TOL);
      end
      chk_all("a5", mk_exp(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0));
      pulse_ack();
      chk_all("a5_ack", mk_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].ack_first) pulse_ack();
         sb_q.push_back(vecs[i].exp);
         send_frame(vecs[i].tx, vecs[i].stop);
         sb_check($sformatf("vec%0d", i));
      end

      // Ack alone clears everything; a second ack with nothing pending changes nothing
      pulse_ack();
      chk_all("ack_clear", mk_exp(8'h81, 1'b0, 1'b0, 1'b0, 1'b0));
      pulse_ack();
      chk_all("ack_idle", mk_exp(8'h81, 1'b0, 1'b0, 1'b0, 1'b0));

      // Ack coinciding with completion of a second byte
      send_frame(8'h11, 1'b1);
      chk_all("pre_same", mk_exp(8'h11, 1'b1, 1'b0, 1'b0, 1'b0));
      if (lat == 0) lat = EXP_LAT;
      fork
         send_frame(8'h22, 1'b1);
         begin
            cyc(lat - 1);
            rx_ack = 1'b1;
            cyc(1);
            rx_ack = 1'b0;
         end
      join
      chk_all("ack_same_cycle", mk_exp(8'h22, 1'b1, 1'b0, 1'b0, 1'b0));

      // Short low glitch is a false start; next frame still received
      pulse_ack();
      uart_rx = 1'b0;
      cyc(9);
      uart_rx = 1'b1;
      cyc(3 * BIT_CYC);
      chk_all("glitch", mk_exp(8'h22, 1'b0, 1'b0, 1'b0, 1'b0));
      send_frame(8'h96, 1'b1);
      chk_all("after_glitch", mk_exp(8'h96, 1'b1, 1'b0, 1'b0, 1'b0));

      // Reset during data bit 4 abandons the frame
      fork
         send_frame(8'hFF, 1'b1);
         begin
            cyc(5 * BIT_CYC + BIT_CYC / 2);
            reset = 1'b0;
            cyc(2);
            chk_all("in_reset", mk_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
            cyc(BIT_CYC);
            reset = 1'b1;
         end
      join
      chk_all("post_reset", mk_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      send_frame(8'h5A, 1'b1);
      chk_all("after_reset", mk_exp(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0));

      // Line held low: one framing error, no retrigger while it stays low
      pulse_ack();
      uart_rx = 1'b0;
      cyc(12 * BIT_CYC);
      chk_all("held_low", mk_exp(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0));
      pulse_ack();
      chk_all("held_low_ack", mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
      cyc(20 * BIT_CYC);
      chk_all("held_low_quiet", mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
      uart_rx = 1'b1;
      cyc(2 * BIT_CYC);

`ifdef UART_RX_PARITY_EN
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      chk_all("parity_bad", mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1));
      pulse_ack();
      chk_all("parity_ack", mk_exp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0));
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      chk_all("parity_good", mk_exp(8'h07, 1'b1, 1'b0, 1'b0, 1'b0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
